// File: rtl/lsu_axi_master_if.sv
// Bundles the CPU-side request/response handshake and the five AXI4-Lite channels of
// the LSU front end. The master modport is the LSU's view; the slave modport is the bus side.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// LSU front end: turns one CPU load/store at a time into an AXI4-Lite transaction,
// with store lane shifting/strobes and load lane extraction plus sign/zero extension.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request; misaligned/illegal ones go straight to S_RSP
// S_RADDR | read address presented, waiting for arready
// S_RDATA | rready high, waiting for rvalid
// S_WRITE | aw and w presented together, each retired by its own done flag
// S_WRESP | bready high, waiting for bvalid
// S_RSP   | one-cycle completion pulse to the CPU
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  lsu_axi_master_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              req_bad;
  logic              accept;
  logic              aw_fire;
  logic              w_fire;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        strb_base;

  assign req_bad = (bus.req_size == 2'd3)
                || (bus.req_size == 2'd1 && bus.req_addr[0])
                || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid && bus.wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.awvalid   = 1'b0;
    bus.wvalid    = 1'b0;
    bus.bready    = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)          state_d = S_RSP;
          else if (bus.req_wen) state_d = S_WRITE;
          else                  state_d = S_RADDR;
        end
      end
      S_RADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid) state_d = S_RSP;
      end
      S_WRITE: begin
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
        // either channel may retire first; leave once both have, possibly this cycle
        if ((aw_done_q || bus.awready) && (w_done_q || bus.wready)) state_d = S_WRESP;
      end
      S_WRESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) state_d = S_RSP;
      end
      S_RSP: begin
        bus.rsp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane     = bus.rdata >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    case (size_q)
      2'd0: load_ext = signed_q ? {{(DATA_W-8){lane[7]}}, lane[7:0]}
                                : {{(DATA_W-8){1'b0}}, lane[7:0]};
      2'd1: load_ext = signed_q ? {{(DATA_W-16){lane[15]}}, lane[15:0]}
                                : {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    case (bus.req_size)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= bus.req_addr;
        size_q    <= bus.req_size;
        signed_q  <= bus.req_signed;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        rdata_q   <= '0;
        err_q     <= req_bad;
        if (!req_bad && !bus.req_wen) begin
          araddr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        end
        if (!req_bad && bus.req_wen) begin
          awaddr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          wdata_q  <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
          wstrb_q  <= strb_base << bus.req_addr[1:0];
        end
      end
      if (state_q == S_WRITE) begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (state_q == S_RDATA && bus.rvalid) begin
        rdata_q <= load_ext;
        err_q   <= (bus.rresp != 2'b00);
      end
      if (state_q == S_WRESP && bus.bvalid) begin
        err_q <= (bus.bresp != 2'b00);
      end
    end
  end

  assign bus.araddr    = araddr_q;
  assign bus.awaddr    = awaddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed cases plus randomized loads/stores
// against an arithmetic reference model and a wait-state-injecting AXI slave.
module tb_lsu_axi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsu_axi_master_if bus ();

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return (a & ((32'd1 << s) - 32'd1)) != 32'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] s, input bit sg);
    int     nb;
    longint v;
    nb = 1 << s;
    v  = (longint'(rd) >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * nb)) - 64'd1);
    if (sg && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] s);
    int m;
    m = ((1 << (1 << s)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [31:0] a);
    longint v;
    v = longint'(wd) << (8 * int'(a[1:0]));
    return v[31:0];
  endfunction

  task automatic slave_idle();
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
  endtask

  // One request; loads use a_w (ar) / d_w (r), stores use a_w (aw) / d_w (w) / x_w (b).
  task automatic run_txn(input string name, input bit wen, input logic [31:0] addr,
                         input logic [1:0] size, input bit sg, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [1:0] resp,
                         input int a_w, input int d_w, input int x_w);
    bit          bad;
    int          exp_lat, lat;
    int          ar_c, r_c, aw_c, w_c, b_c;
    int          data_err;
    bit          ready_low_ok;
    logic [31:0] got_rd, exp_rd;
    logic        got_err;
    logic [29:0] exp_cnt;
    bad = ref_bad(addr, size);
    lat = -1; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    data_err = 0; ready_low_ok = 1'b1; got_rd = '0; got_err = 1'b0;
    if (bad)       exp_lat = 1;
    else if (!wen) exp_lat = 3 + a_w + d_w;
    else           exp_lat = 3 + ((a_w > d_w) ? a_w : d_w) + x_w;

    @(negedge clk);
    check({name, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
    bus.req_size = size; bus.req_signed = sg; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      if (n > 1) @(negedge clk);
      slave_idle();
      if (bus.req_ready) ready_low_ok = 1'b0;
      if (bus.rsp_valid) begin
        lat = n; got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
      end else begin
        if (bus.arvalid) begin
          if (bus.araddr !== (addr & ~32'd3)) data_err++;
          bus.arready = (ar_c >= a_w);
          ar_c++;
        end
        if (bus.rready) begin
          bus.rvalid = (r_c >= d_w);
          bus.rdata  = bus.rvalid ? rd : $urandom;
          bus.rresp  = bus.rvalid ? resp : 2'(($urandom));
          r_c++;
        end
        if (bus.awvalid) begin
          if (bus.awaddr !== (addr & ~32'd3)) data_err++;
          bus.awready = (aw_c >= a_w);
          aw_c++;
        end
        if (bus.wvalid) begin
          if (bus.wdata !== ref_wdata(wd, addr) || bus.wstrb !== ref_strb(addr, size)) data_err++;
          bus.wready = (w_c >= d_w);
          w_c++;
        end
        if (bus.bready) begin
          bus.bvalid = (b_c >= x_w);
          bus.bresp  = bus.bvalid ? resp : 2'(($urandom));
          b_c++;
        end
      end
    end
    slave_idle();

    exp_rd = (bad || wen) ? 32'd0 : ref_load(rd, addr, size, sg);
    if (bad)       exp_cnt = '0;
    else if (!wen) exp_cnt = {6'(a_w + 1), 6'(d_w + 1), 18'd0};
    else           exp_cnt = {12'd0, 6'(a_w + 1), 6'(d_w + 1), 6'(x_w + 1)};
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".rsp_rdata"}, got_rd, exp_rd);
    check({name, ".rsp_err"}, 32'(got_err), 32'(bad || resp != 2'b00));
    check({name, ".chan_cycles"}, 32'({6'(ar_c), 6'(r_c), 6'(aw_c), 6'(w_c), 6'(b_c)}), 32'(exp_cnt));
    check({name, ".axi_payload_errs"}, 32'(data_err), 32'd0);
    check({name, ".ready_low_busy"}, 32'(ready_low_ok), 32'd1);
    if (lat > 0) begin
      @(negedge clk);
      check({name, ".rsp_pulse_end"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
    end
  endtask

  initial begin
    int spurious;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_wdata = '0;
    slave_idle();
    #1;
    check("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check("reset.valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                               bus.bready, bus.rsp_valid, bus.rsp_err}), 32'd0);
    check("reset.addr_data", bus.araddr | bus.awaddr | bus.wdata | bus.rsp_rdata
                             | 32'(bus.wstrb), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn("ld_word",   1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    run_txn("ld_sbyte",  1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0, 32'h80FF_0000, 2'b00, 0, 0, 0);
    run_txn("ld_ubyte",  1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0, 32'h80FF_0000, 2'b00, 0, 0, 0);
    run_txn("st_half",   1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234, 32'h0, 2'b00, 0, 2, 0);
    run_txn("ld_misal",  1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0);
    run_txn("st_berr",   1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 2'b10, 1, 0, 1);
    run_txn("ld_rerr",   1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 32'h0000_0005, 2'b11, 0, 1, 0);
    run_txn("st_wfirst", 1'b1, 32'h8000_0021, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 2'b00, 3, 0, 2);
    run_txn("ld_illegal",1'b0, 32'h8000_0000, 2'd3, 1'b1, 32'h0, 32'hFFFF_FFFF, 2'b00, 0, 0, 0);

    // Reset while arvalid is waiting on a stalled arready.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0040;
    bus.req_size = 2'd2; bus.req_signed = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.arvalid_before", 32'(bus.arvalid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid.outputs", 32'({bus.arvalid, bus.rready, bus.rsp_valid, bus.req_ready}), 32'b0001);
    spurious = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.arvalid) spurious++;
    end
    check("rst_mid.no_rsp", 32'(spurious), 32'd0);
    run_txn("ld_after_rst", 1'b0, 32'h8000_0042, 2'd1, 1'b1, 32'h0, 32'h8001_7FFF, 2'b00, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      bit          r_wen;
      logic [1:0]  r_size, r_resp;
      logic [31:0] r_addr;
      r_wen  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn($sformatf("rnd%0d", i), r_wen, r_addr, r_size, 1'($urandom_range(0, 1)),
              $urandom, $urandom, r_resp,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
